fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 pc_in  in  32  current PC from the PC register.
REQ-005 next_addr  out  32  address to the PC register, sampled by it every cycle.
REQ-006 imem_req / imem_addr  out  1/32  instruction memory request and its address.
REQ-007 imem_ready  in  1  memory accepts the request (imem_req & imem_ready = request handshake).
REQ-008 imem_rvalid / imem_rdata  in  1/32  read data return, one-cycle pulse per accepted request.
REQ-009 instr_valid / instr / instr_pc  out  1/32/32  fetched instruction and its address to decode.
REQ-010 instr_ready  in  1  decode accepts the instruction (instr_valid & instr_ready = delivery).
REQ-011 br_taken / br_off  in  1/16  taken branch; signed word offset.
REQ-012 j_taken / j_target  in  1/26  taken jump; word target field.
REQ-013 misalign_err  out  1  sticky: a fetch address with bits [1:0] != 0 was seen.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, HOLD, ERR.
REQ-015 IDLE: next_addr = RESET_PC; next state REQ; the state SHALL last exactly one cycle after reset release.
REQ-016 REQ: imem_req = 1, imem_addr = pc_in. On handshake go to WAIT. If pc_in[1:0] != 0, go to ERR instead, with no request issued.
REQ-017 WAIT: imem_req = 0. On imem_rvalid, latch instr = imem_rdata and instr_pc = pc_in, then go to HOLD.
REQ-018 HOLD: instr_valid = 1 and instr/instr_pc held stable. On delivery: next_addr = pc_in + 4, go to REQ.
REQ-019 In all other cycles and states, next_addr SHALL equal pc_in, so the PC holds.
REQ-020 PC increment SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-021 Redirect SHALL be br_taken | j_taken; j_taken wins if both are asserted.
- Branch target: instr_pc + 4 + (sign-extended br_off << 2).
- Jump target: {(instr_pc + 4)[31:28], j_target, 2'b00}.
REQ-022 Redirect in HOLD: next_addr = target, instr_valid drops the next cycle, go to REQ. A simultaneous instr_ready SHALL count as consumed with no +4 applied.
REQ-023 Redirect in REQ (no handshake that cycle): next_addr = target, stay in REQ.
REQ-024 Redirect in REQ with handshake, or in WAIT:
- next_addr = target.
- Set a discard flag; the pending imem_rvalid SHALL be dropped and not delivered.
- Then go to REQ.
REQ-025 Redirect in the same cycle as imem_rvalid in WAIT: data discarded, go to REQ.
REQ-026 Redirects in IDLE and ERR SHALL be ignored.
REQ-027 ERR: all request/valid outputs 0, next_addr = pc_in, misalign_err = 1; the state SHALL be left only by reset.
REQ-028 At most one memory request SHALL be outstanding at any time.

Reset
REQ-029 Asserting rst_n low SHALL, without waiting for a clock edge, force the following, even mid-request or mid-delivery:
- state IDLE.
- imem_req = 0, instr_valid = 0.
- instr = 0, instr_pc = 0.
- misalign_err = 0, discard flag = 0.
- next_addr = RESET_PC.
REQ-030 A response arriving after reset release for a pre-reset request SHALL NOT occur at the memory interface; the bench SHALL NOT drive one.

Verification
REQ-031 Reset release, imem_ready = 1, rvalid one cycle later with data 32'h2008_0005, instr_ready = 1 -> fetch at 0x0, instr_valid with instr_pc = 0x0, then next fetch at 0x4.
REQ-032 instr_ready held 0 for 3 cycles in HOLD -> instr/instr_pc stable, next_addr = pc_in, no new imem_req.
REQ-033 br_taken, br_off = 16'hFFFF in HOLD, instr_pc = 0x10 -> next_addr = 0x10, no +4, next fetch at 0x10.
REQ-034 j_taken, j_target = 26'h0000_040 in WAIT, instr_pc = 0x0 -> the pending rvalid is discarded, next fetch at 0x100, no instr_valid for the discarded word.
REQ-035 PC 32'hFFFF_FFFC delivered -> next_addr = 32'h0000_0000. Separately, RESET_PC = 32'h2 -> ERR state, misalign_err = 1, no imem_req.
REQ-036 rst_n low while in WAIT -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the PC register, issues one instruction-memory
// request at a time and hands fetched words to decode, with branch/jump redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic [31:0] next_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        j_taken,
    input  logic [25:0] j_target,
    output logic        misalign_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        discard_q, discard_d;
    logic        misalign_q, misalign_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] next_addr_s;

    logic        redirect_s;
    logic        misaligned_s;
    logic        req_s;
    logic        handshake_s;
    logic [31:0] seq_pc_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;
    logic [31:0] tgt_s;

    assign redirect_s   = br_taken | j_taken;
    assign seq_pc_s     = instr_pc_q + 32'd4;
    assign br_tgt_s     = seq_pc_s + {{14{br_off[15]}}, br_off, 2'b00};
    assign j_tgt_s      = {seq_pc_s[31:28], j_target, 2'b00};
    assign tgt_s        = j_taken ? j_tgt_s : br_tgt_s;
    assign misaligned_s = (pc_in[1:0] != 2'b00);
    // No new request while a squashed response is still due: keeps one in flight.
    assign req_s        = (state_q == S_REQ) && !discard_q && !misaligned_s;
    assign handshake_s  = req_s & imem_ready;

    // Next-state, next-PC and fetched-word capture.
    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        misalign_d  = misalign_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        next_addr_s = pc_in;
        case (state_q)
            S_IDLE: begin
                next_addr_s = RESET_PC;
                state_d     = S_REQ;
            end
            S_REQ: begin
                if (misaligned_s) begin
                    misalign_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    if (discard_q && imem_rvalid) begin
                        discard_d = 1'b0;
                    end else begin
                        discard_d = discard_q;
                    end
                    if (redirect_s) begin
                        next_addr_s = tgt_s;
                    end else begin
                        next_addr_s = pc_in;
                    end
                    if (handshake_s && redirect_s) begin
                        discard_d = 1'b1;
                    end else if (handshake_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_s) begin
                    next_addr_s = tgt_s;
                    discard_d   = !imem_rvalid;
                    state_d     = S_REQ;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_in;
                    state_d    = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    next_addr_s = tgt_s;
                    state_d     = S_REQ;
                end else if (instr_ready) begin
                    next_addr_s = pc_in + 32'd4;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                discard_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and fetched-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            misalign_q <= 1'b0;
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            misalign_q <= misalign_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign next_addr    = next_addr_s;
    assign imem_req     = req_s;
    assign imem_addr    = pc_in;
    assign instr_valid  = (state_q == S_HOLD);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cycle table, hand-written reset/misalign sequences,
// and randomized traffic checked against a queue-based fetch model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc_in;
    logic [31:0] next_addr, imem_addr, instr, instr_pc;
    logic        imem_req, instr_valid, misalign_err;
    logic        imem_ready, imem_rvalid, instr_ready, br_taken, j_taken;
    logic [31:0] imem_rdata;
    logic [15:0] br_off;
    logic [25:0] j_target;

    logic [31:0] pc2;
    logic [31:0] n2, a2, i2, ip2;
    logic        r2, v2, e2;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .next_addr(next_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .br_taken(br_taken), .br_off(br_off),
        .j_taken(j_taken), .j_target(j_target), .misalign_err(misalign_err)
    );

    // Second instance with a misaligned reset address; it must fall into the error state.
    fetch_sequencer #(.RESET_PC(32'h0000_0002)) dut_mis (
        .clk(clk), .rst_n(rst_n), .pc_in(pc2), .next_addr(n2),
        .imem_req(r2), .imem_addr(a2), .imem_ready(1'b1),
        .imem_rvalid(1'b0), .imem_rdata(32'h0000_0000),
        .instr_valid(v2), .instr(i2), .instr_pc(ip2),
        .instr_ready(1'b1), .br_taken(1'b0), .br_off(16'h0000),
        .j_taken(1'b0), .j_target(26'h0000000), .misalign_err(e2)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_cap = 32'h0, pc2_cap = 32'h0;
    logic        req2_seen = 1'b0;

    task automatic chk32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        br_taken = 1'b0; br_off = 16'h0; j_taken = 1'b0; j_target = 26'h0;
    endtask

    // PC registers load next_addr at every rising edge; inputs change just after it.
    task automatic step_begin();
        @(posedge clk);
        #1;
        pc_in = pc_cap;
        pc2   = pc2_cap;
    endtask

    task automatic step_end();
        @(negedge clk);
        pc_cap  = next_addr;
        pc2_cap = n2;
        if (r2) req2_seen = 1'b1;
    endtask

    typedef struct {
        logic rdy; logic rv; logic [31:0] rd; logic irdy;
        logic br; logic [15:0] off; logic j; logic [25:0] jt;
        logic [31:0] pc; logic req; logic val; logic [31:0] nxt; logic [31:0] ins; logic [31:0] ipc;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic irdy, logic br,
                                logic [15:0] off, logic j, logic [25:0] jt, logic [31:0] pc,
                                logic req, logic val, logic [31:0] nxt, logic [31:0] ins, logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.irdy = irdy; v.br = br; v.off = off; v.j = j; v.jt = jt;
        v.pc = pc; v.req = req; v.val = val; v.nxt = nxt; v.ins = ins; v.ipc = ipc;
        return v;
    endfunction

    // Reference model state: the in-flight request (its entry says whether it is squashed),
    // the word awaiting decode, and the last word handed over.
    bit          out_q[$];
    logic [31:0] held_q[$];
    logic        m_first, m_err;
    logic [31:0] m_ins, m_ipc;
    bit          mem_pending;
    int          mem_cnt;

    task automatic model_cycle(input int cyc);
        logic        redirect, e_req, e_val;
        logic [31:0] tgt, e_next, seq;
        int          off_words;
        redirect  = br_taken | j_taken;
        seq       = m_ipc + 32'd4;
        off_words = int'($signed(br_off));
        tgt       = j_taken ? {seq[31:28], j_target, 2'b00} : seq + 32'(off_words * 4);
        e_req = 1'b0; e_val = 1'b0; e_next = pc_in;
        chk32("rnd instr", cyc, instr, m_ins);
        chk32("rnd instr_pc", cyc, instr_pc, m_ipc);
        chk1("rnd misalign_err", cyc, misalign_err, m_err);
        if (m_first) begin
            e_next = 32'h0000_0000;
        end else if (m_err) begin
            e_next = pc_in;
        end else if (held_q.size() != 0) begin
            e_val = 1'b1;
            if (redirect) begin e_next = tgt; void'(held_q.pop_front()); end
            else if (instr_ready) begin e_next = pc_in + 32'd4; void'(held_q.pop_front()); end
        end else if (out_q.size() != 0 && !out_q[0]) begin
            if (redirect) e_next = tgt;
            if (imem_rvalid) begin
                if (!redirect) begin held_q.push_back(imem_rdata); m_ins = imem_rdata; m_ipc = pc_in; end
                void'(out_q.pop_front());
            end else if (redirect) begin
                out_q[0] = 1'b1;
            end
        end else if (pc_in[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else begin
            e_req = (out_q.size() == 0);
            if (imem_rvalid && out_q.size() != 0) void'(out_q.pop_front());
            if (redirect) e_next = tgt;
            if (e_req && imem_ready) out_q.push_back(redirect);
        end
        m_first = 1'b0;
        chk1("rnd imem_req", cyc, imem_req, e_req);
        chk1("rnd instr_valid", cyc, instr_valid, e_val);
        chk32("rnd next_addr", cyc, next_addr, e_next);
        if (e_req) chk32("rnd imem_addr", cyc, imem_addr, pc_in);
    endtask

    vec_t v[42];

    initial begin
        v[0]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h0,1'b0,1'b0,32'h0,32'h0,32'h0);
        v[1]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h0,1'b1,1'b0,32'h0,32'h0,32'h0);
        v[2]  = mk(1'b0,1'b1,32'h2008_0005,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h0,1'b0,1'b0,32'h0,32'h0,32'h0);
        v[3]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'h0,1'b0,1'b1,32'h4,32'h2008_0005,32'h0);
        v[4]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b1,1'b0,32'h4,32'h2008_0005,32'h0);
        v[5]  = mk(1'b0,1'b1,32'hA,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b0,1'b0,32'h4,32'h2008_0005,32'h0);
        v[6]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b0,1'b1,32'h4,32'hA,32'h4);
        v[7]  = v[6];
        v[8]  = v[6];
        v[9]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b0,1'b1,32'h8,32'hA,32'h4);
        v[10] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h8,1'b1,1'b0,32'h8,32'hA,32'h4);
        v[11] = mk(1'b0,1'b1,32'hB,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h8,1'b0,1'b0,32'h8,32'hA,32'h4);
        v[12] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'h8,1'b0,1'b1,32'hC,32'hB,32'h8);
        v[13] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b1,1'b0,32'hC,32'hB,32'h8);
        v[14] = mk(1'b0,1'b1,32'hC,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b0,1'b0,32'hC,32'hB,32'h8);
        v[15] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b0,1'b1,32'h10,32'hC,32'hC);
        v[16] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h10,1'b1,1'b0,32'h10,32'hC,32'hC);
        v[17] = mk(1'b0,1'b1,32'hD,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h10,1'b0,1'b0,32'h10,32'hC,32'hC);
        v[18] = mk(1'b0,1'b0,32'h0,1'b1,1'b1,16'hFFFF,1'b0,26'h0, 32'h10,1'b0,1'b1,32'h10,32'hD,32'h10);
        v[19] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h10,1'b1,1'b0,32'h10,32'hD,32'h10);
        v[20] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b1,26'h40, 32'h10,1'b0,1'b0,32'h100,32'hD,32'h10);
        v[21] = mk(1'b1,1'b1,32'hDEAD,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h100,1'b0,1'b0,32'h100,32'hD,32'h10);
        v[22] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h100,1'b1,1'b0,32'h100,32'hD,32'h10);
        v[23] = mk(1'b0,1'b1,32'hE,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h100,1'b0,1'b0,32'h100,32'hD,32'h10);
        v[24] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'hFFBE,1'b0,26'h0, 32'h100,1'b0,1'b1,32'hFFFF_FFFC,32'hE,32'h100);
        v[25] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hFFFF_FFFC,1'b1,1'b0,32'hFFFF_FFFC,32'hE,32'h100);
        v[26] = mk(1'b0,1'b1,32'hF,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hFFFF_FFFC,1'b0,1'b0,32'hFFFF_FFFC,32'hE,32'h100);
        v[27] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'hFFFF_FFFC,1'b0,1'b1,32'h0,32'hF,32'hFFFF_FFFC);
        v[28] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h0,1'b1,1'b0,32'h0,32'hF,32'hFFFF_FFFC);
        v[29] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'h0003,1'b0,26'h0, 32'h0,1'b1,1'b0,32'hC,32'hF,32'hFFFF_FFFC);
        v[30] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b1,26'h3, 32'hC,1'b1,1'b0,32'hC,32'hF,32'hFFFF_FFFC);
        v[31] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b0,1'b0,32'hC,32'hF,32'hFFFF_FFFC);
        v[32] = mk(1'b1,1'b1,32'h1234_5678,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b0,1'b0,32'hC,32'hF,32'hFFFF_FFFC);
        v[33] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'hC,1'b1,1'b0,32'hC,32'hF,32'hFFFF_FFFC);
        v[34] = mk(1'b0,1'b1,32'h77,1'b0,1'b1,16'h0001,1'b0,26'h0, 32'hC,1'b0,1'b0,32'h4,32'hF,32'hFFFF_FFFC);
        v[35] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b1,1'b0,32'h4,32'hF,32'hFFFF_FFFC);
        v[36] = mk(1'b0,1'b1,32'h55,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h4,1'b0,1'b0,32'h4,32'hF,32'hFFFF_FFFC);
        v[37] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'h0001,1'b1,26'h10, 32'h4,1'b0,1'b1,32'h40,32'h55,32'h4);
        v[38] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h40,1'b1,1'b0,32'h40,32'h55,32'h4);
        v[39] = mk(1'b0,1'b1,32'h99,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h40,1'b0,1'b0,32'h40,32'h55,32'h4);
        v[40] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0,26'h0, 32'h40,1'b0,1'b1,32'h44,32'h99,32'h40);
        v[41] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0,26'h0, 32'h44,1'b1,1'b0,32'h44,32'h99,32'h40);

        rst_n = 1'b0; pc_in = 32'h0; pc2 = 32'h0;
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin step_begin(); step_end(); end

        // Directed table; reset is released inside row 0 so that row 0 is the IDLE cycle.
        for (int i = 0; i < 42; i++) begin
            step_begin();
            if (i == 0) rst_n = 1'b1;
            imem_ready = v[i].rdy; imem_rvalid = v[i].rv; imem_rdata = v[i].rd; instr_ready = v[i].irdy;
            br_taken = v[i].br; br_off = v[i].off; j_taken = v[i].j; j_target = v[i].jt;
            step_end();
            chk32("tbl pc_in", i, pc_in, v[i].pc);
            chk32("tbl next_addr", i, next_addr, v[i].nxt);
            chk1("tbl imem_req", i, imem_req, v[i].req);
            chk1("tbl instr_valid", i, instr_valid, v[i].val);
            chk32("tbl instr", i, instr, v[i].ins);
            chk32("tbl instr_pc", i, instr_pc, v[i].ipc);
            chk1("tbl misalign_err", i, misalign_err, 1'b0);
            if (v[i].req) chk32("tbl imem_addr", i, imem_addr, v[i].pc);
        end

        chk1("mis misalign_err", 0, e2, 1'b1);
        chk1("mis req_ever", 0, req2_seen, 1'b0);
        chk1("mis instr_valid", 0, v2, 1'b0);
        chk32("mis next_addr", 0, n2, 32'h0000_0002);

        // Reset asserted mid-cycle while a request is in flight.
        step_begin();
        quiet_inputs();
        imem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst imem_req", 0, imem_req, 1'b0);
        chk1("rst instr_valid", 0, instr_valid, 1'b0);
        chk32("rst instr", 0, instr, 32'h0);
        chk32("rst instr_pc", 0, instr_pc, 32'h0);
        chk1("rst misalign_err", 0, misalign_err, 1'b0);
        chk32("rst next_addr", 0, next_addr, 32'h0);
        chk1("rst mis misalign_err", 0, e2, 1'b0);
        chk32("rst mis next_addr", 0, n2, 32'h0000_0002);
        step_end();
        for (int i = 0; i < 2; i++) begin step_begin(); step_end(); end
        step_begin(); rst_n = 1'b1; imem_ready = 1'b1; step_end();
        chk32("restart idle next_addr", 0, next_addr, 32'h0);
        chk1("restart idle imem_req", 0, imem_req, 1'b0);
        step_begin(); step_end();
        chk1("restart imem_req", 0, imem_req, 1'b1);
        chk32("restart imem_addr", 0, imem_addr, 32'h0);

        // Randomized traffic against the model, starting from a fresh reset.
        rst_n = 1'b0;
        quiet_inputs();
        for (int i = 0; i < 2; i++) begin step_begin(); step_end(); end
        out_q.delete(); held_q.delete();
        m_first = 1'b1; m_err = 1'b0; m_ins = 32'h0; m_ipc = 32'h0;
        mem_pending = 1'b0; mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step_begin();
            if (cyc == 0) rst_n = 1'b1;
            imem_ready = ($urandom_range(3) != 0);
            imem_rdata = $urandom;
            if (mem_pending && mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                mem_pending = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (mem_pending) mem_cnt--;
            end
            instr_ready = ($urandom_range(2) != 0);
            br_taken    = ($urandom_range(9) == 0);
            j_taken     = ($urandom_range(14) == 0);
            br_off      = 16'($urandom);
            j_target    = 26'($urandom);
            step_end();
            model_cycle(cyc);
            if (imem_req && imem_ready && !mem_pending) begin
                mem_pending = 1'b1;
                mem_cnt     = $urandom_range(2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
